// File: rtl/ws2812_pkg.sv
// Shared constants, state encoding and helpers for the WS2812B receiver.
// Driver timing is expressed in 12 MHz clocks (one tick = 4 clocks).
package ws2812_pkg;

    localparam int BITS_PER_PIXEL  = 24;
    localparam int CLKS_PER_TICK   = 4;
    localparam int T0H_CLKS        = 4;
    localparam int T1H_CLKS        = 12;
    localparam int BIT_PERIOD_CLKS = 16;

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        IDLE = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } rx_state_e;

    // Increment that sticks at 255 so long frames still report a sane count.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/ws2812_rx_sync2.sv
// Two-flop synchronizer for the asynchronous data line, followed by a
// registered previous-level flop used for rising/falling edge detection.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic din_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= din_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign rise_o  = sync_q & ~prev_q;
    assign fall_o  = ~sync_q & prev_q;

endmodule

// File: rtl/ws2812_rx.sv
// WS2812B stream receiver: classifies bits by high-pulse width, assembles
// 24-bit pixels with a frame index and reports latch gaps and protocol errors.
module ws2812_rx
    import ws2812_pkg::*;
#(
    parameter int unsigned HIGH_THRESH = 8,
    parameter int unsigned MIN_HIGH    = 2,
    parameter int unsigned MAX_HIGH    = 20,
    parameter int unsigned RESET_CLKS  = 600,
    parameter int unsigned NUM_LEDS    = 60
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        din,
    output logic [23:0] pixel_data,
    output logic        pixel_valid,
    output logic [7:0]  pixel_idx,
    output logic        frame_done,
    output logic [7:0]  frame_pixels,
    output logic        frame_err,
    output logic        busy
);

    localparam int HIGH_W = $clog2(MAX_HIGH + 2);
    localparam int LOW_W  = $clog2(RESET_CLKS + 1);
    localparam int BIT_W  = $clog2(BITS_PER_PIXEL);

    localparam logic [HIGH_W-1:0] THRESH_C   = HIGH_W'(HIGH_THRESH);
    localparam logic [HIGH_W-1:0] MIN_HIGH_C = HIGH_W'(MIN_HIGH);
    localparam logic [HIGH_W-1:0] MAX_HIGH_C = HIGH_W'(MAX_HIGH);
    localparam logic [HIGH_W-1:0] HIGH_SAT_C = HIGH_W'(MAX_HIGH + 1);
    localparam logic [LOW_W-1:0]  RESET_C    = LOW_W'(RESET_CLKS);
    localparam logic [BIT_W-1:0]  LAST_BIT_C = BIT_W'(BITS_PER_PIXEL - 1);
    localparam logic [7:0]        NUM_LEDS_C = 8'(NUM_LEDS);

    logic line_level;
    logic line_rise;
    logic line_fall;

    sync2 u_sync2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .din_i   (din),
        .level_o (line_level),
        .rise_o  (line_rise),
        .fall_o  (line_fall)
    );

    rx_state_e           state_q, state_d;
    logic [HIGH_W-1:0]   high_cnt_q, high_cnt_d;
    logic [LOW_W-1:0]    low_cnt_q, low_cnt_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]          pix_cnt_q, pix_cnt_d;
    logic [23:0]         word_q, word_d;
    logic                busy_q, busy_d;
    logic                pixel_valid_q, pixel_valid_d;
    logic [23:0]         pixel_data_q, pixel_data_d;
    logic [7:0]          pixel_idx_q, pixel_idx_d;
    logic                frame_done_q, frame_done_d;
    logic [7:0]          frame_pixels_q, frame_pixels_d;
    logic                frame_err_q, frame_err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= SYNC;
            high_cnt_q     <= '0;
            low_cnt_q      <= '0;
            bit_cnt_q      <= '0;
            pix_cnt_q      <= '0;
            word_q         <= '0;
            busy_q         <= 1'b0;
            pixel_valid_q  <= 1'b0;
            pixel_data_q   <= '0;
            pixel_idx_q    <= '0;
            frame_done_q   <= 1'b0;
            frame_pixels_q <= '0;
            frame_err_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            high_cnt_q     <= high_cnt_d;
            low_cnt_q      <= low_cnt_d;
            bit_cnt_q      <= bit_cnt_d;
            pix_cnt_q      <= pix_cnt_d;
            word_q         <= word_d;
            busy_q         <= busy_d;
            pixel_valid_q  <= pixel_valid_d;
            pixel_data_q   <= pixel_data_d;
            pixel_idx_q    <= pixel_idx_d;
            frame_done_q   <= frame_done_d;
            frame_pixels_q <= frame_pixels_d;
            frame_err_q    <= frame_err_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        high_cnt_d     = high_cnt_q;
        low_cnt_d      = low_cnt_q;
        bit_cnt_d      = bit_cnt_q;
        pix_cnt_d      = pix_cnt_q;
        word_d         = word_q;
        busy_d         = busy_q;
        pixel_valid_d  = 1'b0;
        pixel_data_d   = pixel_data_q;
        pixel_idx_d    = pixel_idx_q;
        frame_done_d   = 1'b0;
        frame_pixels_d = frame_pixels_q;
        frame_err_d    = 1'b0;

        case (state_q)
            // Wait for a full latch-length low before trusting bit boundaries.
            SYNC: begin
                if (line_level) begin
                    low_cnt_d = '0;
                end else if (low_cnt_q == RESET_C - LOW_W'(1)) begin
                    low_cnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    low_cnt_d = low_cnt_q + LOW_W'(1);
                end
            end

            IDLE: begin
                if (line_rise) begin
                    state_d    = HIGH;
                    high_cnt_d = HIGH_W'(1);
                    busy_d     = 1'b1;
                end
            end

            HIGH: begin
                if (high_cnt_q > MAX_HIGH_C || (line_fall && high_cnt_q < MIN_HIGH_C)) begin
                    frame_err_d = 1'b1;
                    busy_d      = 1'b0;
                    bit_cnt_d   = '0;
                    pix_cnt_d   = '0;
                    word_d      = '0;
                    low_cnt_d   = '0;
                    state_d     = SYNC;
                end else if (line_fall) begin
                    word_d[bit_cnt_q] = (high_cnt_q >= THRESH_C);
                    if (bit_cnt_q == LAST_BIT_C) begin
                        bit_cnt_d = '0;
                        if (pix_cnt_q < NUM_LEDS_C) begin
                            pixel_valid_d = 1'b1;
                            pixel_data_d  = word_d;
                            pixel_idx_d   = pix_cnt_q;
                        end
                        pix_cnt_d = sat_inc8(pix_cnt_q);
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                    low_cnt_d = LOW_W'(1);
                    state_d   = LOW;
                end else if (high_cnt_q != HIGH_SAT_C) begin
                    high_cnt_d = high_cnt_q + HIGH_W'(1);
                end
            end

            LOW: begin
                if (line_rise) begin
                    high_cnt_d = HIGH_W'(1);
                    state_d    = HIGH;
                end else if (low_cnt_q == RESET_C) begin
                    // Latch gap: a leftover partial word or too many pixels is an error.
                    frame_err_d    = (bit_cnt_q != '0) || (pix_cnt_q > NUM_LEDS_C);
                    frame_done_d   = 1'b1;
                    frame_pixels_d = pix_cnt_q;
                    bit_cnt_d      = '0;
                    pix_cnt_d      = '0;
                    busy_d         = 1'b0;
                    low_cnt_d      = '0;
                    state_d        = IDLE;
                end else begin
                    low_cnt_d = low_cnt_q + LOW_W'(1);
                end
            end

            default: begin
                state_d = SYNC;
            end
        endcase
    end

    assign pixel_data   = pixel_data_q;
    assign pixel_valid  = pixel_valid_q;
    assign pixel_idx    = pixel_idx_q;
    assign frame_done   = frame_done_q;
    assign frame_pixels = frame_pixels_q;
    assign frame_err    = frame_err_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_ws2812_rx.sv
// Directed bench for ws2812_rx: a stream-level model queues the expected pixel
// and frame strobes while a per-cycle compare process checks the DUT outputs.
`timescale 1ns/1ps
module tb_ws2812_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        din = 1'b0;
    logic [23:0] pixel_data;
    logic        pixel_valid;
    logic [7:0]  pixel_idx;
    logic        frame_done;
    logic [7:0]  frame_pixels;
    logic        frame_err;
    logic        busy;

    always #5 clk = ~clk;

    ws2812_rx dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .din          (din),
        .pixel_data   (pixel_data),
        .pixel_valid  (pixel_valid),
        .pixel_idx    (pixel_idx),
        .frame_done   (frame_done),
        .frame_pixels (frame_pixels),
        .frame_err    (frame_err),
        .busy         (busy)
    );

    typedef struct packed { logic [23:0] data; logic [7:0] idx; } pix_t;
    typedef struct packed { logic done; logic err; logic [7:0] pixels; } frm_t;

    pix_t exp_pix[$];
    frm_t exp_frm[$];
    pix_t cur_pix;
    frm_t cur_frm;

    int model_pix  = 0;
    int model_bits = 0;
    int checks     = 0;
    int passed     = 0;

    int          n_pv = 0;
    int          n_fd = 0;
    int          n_fe = 0;
    logic [23:0] last_data  = '0;
    logic [7:0]  last_idx   = '0;
    logic [7:0]  last_fp    = '0;
    logic [1:0]  last_flags = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    // Per-cycle compare against the model queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (pixel_valid) begin
                n_pv++;
                last_data = pixel_data;
                last_idx  = pixel_idx;
                if (exp_pix.size() == 0) begin
                    chk("pixel_valid unexpected", 32'(pixel_valid), 32'd0);
                end else begin
                    cur_pix = exp_pix.pop_front();
                    chk("pixel_data", 32'(pixel_data), 32'(cur_pix.data));
                    chk("pixel_idx", 32'(pixel_idx), 32'(cur_pix.idx));
                end
            end
            if (frame_done || frame_err) begin
                n_fd += int'(frame_done);
                n_fe += int'(frame_err);
                last_flags = {frame_done, frame_err};
                if (frame_done) last_fp = frame_pixels;
                if (exp_frm.size() == 0) begin
                    chk("frame strobe unexpected", 32'({frame_done, frame_err}), 32'd0);
                end else begin
                    cur_frm = exp_frm.pop_front();
                    chk("frame_done", 32'(frame_done), 32'(cur_frm.done));
                    chk("frame_err", 32'(frame_err), 32'(cur_frm.err));
                    if (cur_frm.done) chk("frame_pixels", 32'(frame_pixels), 32'(cur_frm.pixels));
                end
            end
        end
    end

    task automatic hold(input logic v, input int n);
        din = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        hold(1'b1, b ? 12 : 4);
        hold(1'b0, b ? 4 : 12);
    endtask

    task automatic send_word(input logic [23:0] w);
        pix_t p;
        if (model_pix < 60) begin
            p.data = w;
            p.idx  = 8'(model_pix);
            exp_pix.push_back(p);
        end
        for (int i = 0; i < 24; i++) send_bit(w[i]);
        model_pix++;
    endtask

    task automatic send_bits(input logic [23:0] w, input int n);
        for (int i = 0; i < n; i++) send_bit(w[i]);
        model_bits = (model_bits + n) % 24;
    endtask

    task automatic latch(input int n);
        frm_t f;
        f.done   = 1'b1;
        f.err    = (model_bits != 0) || (model_pix > 60);
        f.pixels = (model_pix > 255) ? 8'd255 : 8'(model_pix);
        exp_frm.push_back(f);
        hold(1'b0, n);
        model_pix  = 0;
        model_bits = 0;
    endtask

    task automatic expect_err();
        frm_t f;
        f.done   = 1'b0;
        f.err    = 1'b1;
        f.pixels = 8'd0;
        exp_frm.push_back(f);
        model_pix  = 0;
        model_bits = 0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 64 && (exp_pix.size() != 0 || exp_frm.size() != 0); i++)
            @(negedge clk);
        chk(name, 32'(exp_pix.size() + exp_frm.size()), 32'd0);
    endtask

    task automatic clear_counts();
        n_pv = 0;
        n_fd = 0;
        n_fe = 0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset pixel_valid", 32'(pixel_valid), 32'd0);
        chk("reset pixel_data", 32'(pixel_data), 32'd0);
        chk("reset pixel_idx", 32'(pixel_idx), 32'd0);
        chk("reset frame_done", 32'(frame_done), 32'd0);
        chk("reset frame_pixels", 32'(frame_pixels), 32'd0);
        chk("reset frame_err", 32'(frame_err), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        hold(1'b0, 700);

        // Single pixel
        clear_counts();
        send_word(24'h123456);
        chk("single busy mid-frame", 32'(busy), 32'd1);
        latch(8192);
        drain("single drained");
        chk("single pixel count", 32'(n_pv), 32'd1);
        chk("single data literal", 32'(last_data), 32'h123456);
        chk("single idx literal", 32'(last_idx), 32'd0);
        chk("single frame_pixels literal", 32'(last_fp), 32'd1);
        chk("single err count", 32'(n_fe), 32'd0);
        chk("single busy after latch", 32'(busy), 32'd0);

        // Full frame
        clear_counts();
        for (int k = 0; k < 60; k++) send_word(24'(k * 32'h010101));
        latch(700);
        drain("full drained");
        chk("full pixel count", 32'(n_pv), 32'd60);
        chk("full last idx", 32'(last_idx), 32'd59);
        chk("full last data", 32'(last_data), 32'h3B3B3B);
        chk("full frame_pixels", 32'(last_fp), 32'd60);
        chk("full err count", 32'(n_fe), 32'd0);

        // Overflow
        clear_counts();
        for (int k = 0; k < 61; k++) send_word(24'(k * 32'h010101));
        latch(700);
        drain("overflow drained");
        chk("overflow pixel count", 32'(n_pv), 32'd60);
        chk("overflow frame_pixels", 32'(last_fp), 32'd61);
        chk("overflow done+err flags", 32'(last_flags), 32'd3);

        // Partial pixel
        clear_counts();
        send_bits(24'hFFFFFF, 10);
        latch(700);
        drain("partial drained");
        chk("partial pixel count", 32'(n_pv), 32'd0);
        chk("partial frame_pixels", 32'(last_fp), 32'd0);
        chk("partial done+err flags", 32'(last_flags), 32'd3);

        // One-clock glitch, resync, then a clean pixel
        clear_counts();
        expect_err();
        hold(1'b1, 1);
        hold(1'b0, 700);
        send_word(24'hABCDEF);
        latch(700);
        drain("glitch drained");
        chk("glitch err count", 32'(n_fe), 32'd1);
        chk("glitch recovery data", 32'(last_data), 32'hABCDEF);
        chk("glitch recovery idx", 32'(last_idx), 32'd0);

        // Stuck high
        clear_counts();
        expect_err();
        hold(1'b1, 25);
        hold(1'b0, 700);
        drain("stuck drained");
        chk("stuck err-only flags", 32'(last_flags), 32'd1);
        chk("stuck busy cleared", 32'(busy), 32'd0);

        // Reset in the middle of a pixel
        clear_counts();
        send_word(24'h5A5A5A);
        send_bits(24'hFFFFFF, 12);
        drain("pre-reset drained");
        chk("pre-reset busy", 32'(busy), 32'd1);
        chk("pre-reset data", 32'(pixel_data), 32'h5A5A5A);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset outputs", 32'({pixel_data, pixel_valid, busy, frame_done, frame_err}), 32'd0);
        chk("async reset idx/fp", 32'({pixel_idx, frame_pixels}), 32'd0);
        model_pix  = 0;
        model_bits = 0;
        @(negedge clk);
        rst_n = 1'b1;
        clear_counts();
        send_bits(24'hFFFFFF, 12);
        model_bits = 0;
        chk("post-reset no strobes", 32'(n_pv + n_fd + n_fe), 32'd0);
        hold(1'b0, 700);
        send_word(24'h00F00F);
        latch(700);
        drain("post-reset drained");
        chk("post-reset idx", 32'(last_idx), 32'd0);
        chk("post-reset frame_pixels", 32'(last_fp), 32'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
